stage_mem: RTL
==============

Name: stage_mem

Overview:
- MIPS MEM pipeline stage. It consumes the registered EXE-stage bundle (ALU result, store data, control bits, branch/jump flags) and resolves the next-PC select for the IF stage.
- Performs data-memory loads/stores over a req/ack handshake and stalls the pipeline while an access is outstanding.
- Registers the MEM/WB bundle for write-back.
- Supplies the MEM-stage result used by EXE forwarding.

Parameters:
- TIMEOUT, 16, max cycles waiting for dmem_ack before the access is abandoned (≥1).
- ADDR_LSB, 2, low address bits dropped to form the word address on dmem_addr.

Ports:
- clock in 1: rising-edge clock.
- reset in 1: asynchronous, active-high reset.
- is_jump in 1: EXE jump flag.
- branch_eq in 1: EXE branch-if-equal flag.
- branch_inc in 1: EXE branch-if-not-equal flag.
- zero in 1: EXE ALU zero flag.
- jump_address in 32: EXE computed branch/jump target.
- wbi in 2: [1]=reg_write, [0]=mem_to_reg (load).
- M in 1: memory write (store).
- regaddr in 5: destination register.
- data_b in 32: store data.
- alu_out in 32: ALU result / memory byte address.
- pcsrc out 1: IF selects branch_target.
- branch_target out 32: next PC when pcsrc=1.
- stall out 1: freeze IF/ID/EXE registers.
- fwd_result out 32: MEM-stage value for EXE forwarding (=alu_out).
- dmem_req out 1: memory request.
- dmem_we out 1: 1=write.
- dmem_addr out 30: alu_out[31:ADDR_LSB].
- dmem_wdata out 32: =data_b.
- dmem_rdata in 32: read data, valid with dmem_ack.
- dmem_ack in 1: access complete.
- wbi_o out 2: registered wbi.
- regaddr_o out 5: registered regaddr.
- alu_out_o out 32: registered alu_out.
- mem_data_o out 32: registered load data.
- bus_err_o out 1: registered; 1 for the WB slot of an abandoned access.

Behaviour:
- Combinational outputs:
  - pcsrc = is_jump | (branch_eq & zero) | (branch_inc & ~zero).
  - branch_target = jump_address.
  - A bubble (all controls 0) gives pcsrc=0.
- access = M | wbi[0]. M and wbi[0] both set is illegal; M wins (write).
- FSM with states IDLE and WAIT, plus wait counter cnt:
  - dmem_req = access in IDLE, 1 in WAIT. dmem_we = M. Address and wdata are driven straight from inputs; upstream holds them stable while stalled.
  - IDLE: access & ~dmem_ack → WAIT, cnt=1. access & dmem_ack → stay IDLE (zero-wait access).
  - WAIT: dmem_ack → IDLE. cnt==TIMEOUT → IDLE with timeout. Otherwise cnt+1.
  - stall = dmem_req & ~dmem_ack & ~timeout. It deasserts in the ack/timeout cycle, so upstream advances at that edge and the access is never reissued.
- MEM/WB register, updated at posedge:
  - stall=1: load a bubble (wbi_o=0, bus_err_o=0, other fields don't-care/held). Prevents double write-back.
  - stall=0: capture wbi, regaddr, alu_out. mem_data_o = dmem_rdata if the ack was taken this cycle, else 0.
  - Timeout: mem_data_o=0, bus_err_o=1, wbi_o[1] forced 0 (no register write). Stores are dropped silently apart from bus_err_o.
- Latency: one cycle from EXE bundle to WB outputs with zero-wait memory; plus N cycles for N wait states.
- Reset (asynchronous, any time including mid-WAIT):
  - FSM→IDLE, cnt=0, all registered outputs 0.
  - dmem_req depends only on inputs in IDLE, so it drops to 0 whenever inputs are a bubble.
- dmem_ack while dmem_req=0 is ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined: access with alu_out[1:0]≠0 is misaligned.
  - dmem_req is suppressed and no stall occurs.
  - WB slot gets bus_err_o=1, wbi_o[1]=0, mem_data_o=0.
- When undefined: low bits are ignored and the access proceeds to the truncated word address.

Decomposition:
- Shared package mips_pkg:
  - WBI_REGWRITE=1, WBI_MEMTOREG=0 bit indices.
  - FSM state encodings S_IDLE/S_WAIT.
  - BUBBLE_WBI=2'b00.
- One natural sub-module: dmem_port_fsm, holding the IDLE/WAIT FSM, timeout counter, req/stall/timeout generation.
- Branch logic and the MEM/WB register stay in stage_mem.

Test Plan:
- Branch resolution, all combinational, ack irrelevant:
  - branch_eq=1, zero=1, jump_address=0x40 → pcsrc=1, branch_target=0x40.
  - branch_inc=1, zero=1 → pcsrc=0.
  - is_jump=1 → pcsrc=1.
- Zero-wait load: wbi=2'b11, alu_out=0x100, ack held 1, rdata=0xCAFEF00D → dmem_addr=0x40, stall=0, next cycle wbi_o=2'b11, mem_data_o=0xCAFEF00D.
- 3-wait store: M=1, data_b=0x12345678, ack after 3 cycles → stall=1 for 3 cycles, dmem_we=1, WB gets 3 bubbles then wbi_o=captured, bus_err_o=0.
- Timeout: load with ack never asserted, TIMEOUT=16 → stall high 16 cycles, then bus_err_o=1, wbi_o[1]=0, FSM back to IDLE.
- Reset mid-WAIT: assert reset asynchronously in cycle 2 of a wait → all outputs 0 immediately, FSM IDLE. After release, a new zero-wait load completes normally.
- With MEM_ALIGN_CHECK_EN: load at alu_out=0x102 → dmem_req=0, stall=0, next cycle bus_err_o=1, wbi_o[1]=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: write-back control bit indices, MEM-stage FSM states
// and the MEM/WB payload.
package mips_pkg;

    localparam int unsigned WBI_REGWRITE = 1;
    localparam int unsigned WBI_MEMTOREG = 0;

    localparam logic [1:0] BUBBLE_WBI = 2'b00;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [1:0]  wbi;
        logic [4:0]  regaddr;
        logic [31:0] alu_out;
        logic [31:0] mem_data;
        logic        bus_err;
    } mem_wb_t;

    // Word accesses must have the two byte-offset bits clear.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_port_fsm.sv
// Data-memory handshake FSM: tracks an outstanding req until ack or TIMEOUT wait cycles
// and produces the combinational req/stall/timeout strobes.
module dmem_port_fsm
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic access,
    input  logic ack,
    output logic req_c,
    output logic stall_c,
    output logic timeout_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t       state;
    mem_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // An ack in the final wait cycle still wins over the timeout.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_c     = 1'b0;
        timeout_c = 1'b0;
        case (state)
            S_IDLE: begin
                req_c = access;
                if (access && !ack) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                req_c = 1'b1;
                if (ack) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    timeout_c = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        stall_c = req_c & ~ack & ~timeout_c;
    end

endmodule

// File: rtl/stage_mem.sv
// MIPS MEM stage: branch/jump resolution, data-memory access with stall, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN rejects word accesses whose byte offset is non-zero.
module stage_mem
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_jump,
    input  logic        branch_eq,
    input  logic        branch_inc,
    input  logic        zero,
    input  logic [31:0] jump_address,
    input  logic [1:0]  wbi,
    input  logic        M,
    input  logic [4:0]  regaddr,
    input  logic [31:0] data_b,
    input  logic [31:0] alu_out,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic [31:0] fwd_result,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [1:0]  wbi_o,
    output logic [4:0]  regaddr_o,
    output logic [31:0] alu_out_o,
    output logic [31:0] mem_data_o,
    output logic        bus_err_o
);

    logic    access;
    logic    misaligned;
    logic    port_access;
    logic    ack_taken;
    logic    timeout;
    logic    wb_err;
    mem_wb_t wb_d;
    mem_wb_t wb_q;

    assign pcsrc         = is_jump | (branch_eq & zero) | (branch_inc & ~zero);
    assign branch_target = jump_address;
    assign fwd_result    = alu_out;

    // A store with mem_to_reg also set is treated as a store.
    assign access = M | wbi[WBI_MEMTOREG];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access & is_misaligned(alu_out);
`else
    assign misaligned = 1'b0;
`endif

    assign port_access = access & ~misaligned;

    dmem_port_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_port (
        .clock     (clock),
        .reset     (reset),
        .access    (port_access),
        .ack       (dmem_ack),
        .req_c     (dmem_req),
        .stall_c   (stall),
        .timeout_c (timeout)
    );

    assign dmem_we    = M;
    assign dmem_addr  = 30'(alu_out >> ADDR_LSB);
    assign dmem_wdata = data_b;

    assign ack_taken = dmem_req & dmem_ack;
    assign wb_err    = timeout | misaligned;

    // Failed accesses still reach WB, but never write the register file.
    always_comb begin
        wb_d.wbi      = wbi;
        wb_d.regaddr  = regaddr;
        wb_d.alu_out  = alu_out;
        wb_d.mem_data = ack_taken ? dmem_rdata : 32'h0;
        wb_d.bus_err  = wb_err;
        if (wb_err) begin
            wb_d.wbi[WBI_REGWRITE] = 1'b0;
        end
    end

    // While stalled, WB sees bubbles so the pending instruction retires exactly once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_q <= '0;
        end else if (stall) begin
            wb_q.wbi     <= BUBBLE_WBI;
            wb_q.bus_err <= 1'b0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wbi_o      = wb_q.wbi;
    assign regaddr_o  = wb_q.regaddr;
    assign alu_out_o  = wb_q.alu_out;
    assign mem_data_o = wb_q.mem_data;
    assign bus_err_o  = wb_q.bus_err;

endmodule
